l2_response_queue: RTL and testbench
====================================

Name: l2_response_queue

Overview:
- Sits directly downstream of the L2 update stage. Captures each response packet the update stage emits and buffers it in a FIFO.
- Presents packets to the core interconnect with valid/ready flow control, so a slow consumer never loses responses.
- The update stage cannot stall. Backpressure therefore goes upstream as an almost-full signal, which the L2 request arbiter uses to stop admitting new requests.

Parameters:
- FIFO_DEPTH, 8, number of buffered response packets; power of two, minimum 4.
- PIPELINE_SLACK, 4, number of responses that can still arrive after almost-full asserts (L2 pipeline depth).
- ALMOST_FULL_THRESHOLD, FIFO_DEPTH - PIPELINE_SLACK, occupancy at or above which l2rq_almost_full asserts.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low reset; 0 on a rising edge resets the block.
- l2_response_valid  in  1  response packet valid from the update stage; cannot be stalled.
- l2_response  in  $bits(l2rsp_packet_t)  response packet (status, core, id, packet_type, cache_type, data, address).
- l2rq_response_valid  out  1  head-of-queue packet valid to the cores.
- l2rq_response  out  $bits(l2rsp_packet_t)  head-of-queue packet.
- l2rq_response_ready  in  1  consumer accepts the head packet this cycle.
- l2rq_almost_full  out  1  tells the L2 arbiter to stop issuing new requests.
- l2rq_overflow  out  1  sticky error flag: a packet was dropped.
- l2rq_occupancy  out  $clog2(FIFO_DEPTH)+1  current entry count.

Behaviour:
- Storage: FIFO_DEPTH x l2rsp_packet_t array, head and tail pointers of $clog2(FIFO_DEPTH) bits, and an occupancy count.
  - Pointers wrap modulo FIFO_DEPTH.
  - Count range is 0..FIFO_DEPTH.
- Push: when l2_response_valid=1 and the queue is not full, or is full but a pop occurs in the same cycle. Writes the entry at the tail and increments the tail.
- Pop: when l2rq_response_valid=1 and l2rq_response_ready=1. Increments the head.
- Occupancy update, registered:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on simultaneous push and pop, including when full and when count=1.
- Latency: a packet pushed in cycle N is visible on l2rq_response no earlier than cycle N+1. There is no combinational bypass from input to output.
- Output rules:
  - l2rq_response_valid = (occupancy != 0).
  - l2rq_response shows the head entry and stays stable while valid=1 and ready=0.
  - ready while valid=0 has no effect.
- l2rq_almost_full = (occupancy >= ALMOST_FULL_THRESHOLD), driven from the registered count. Deasserts in the cycle after occupancy drops below the threshold.
- Full with push and no pop:
  - The packet is dropped.
  - l2rq_overflow is set to 1 and held until reset.
  - Occupancy, pointers and stored data are unchanged.
  - A simulation-only assertion fires.
- Empty with pop attempted: impossible by construction, since valid=0.
- Reset (reset=0 at an edge), including mid-operation:
  - Pointers and occupancy go to 0; l2rq_response_valid=0, l2rq_almost_full=0, l2rq_overflow=0.
  - All queued packets are discarded.
  - A push presented in the reset cycle is ignored.
  - Array contents are not reset.
- Packet contents pass through bit-exact. The block does not interpret or modify any field.

Decomposition:
- The l2rsp_packet_t type and L2RSP_* encodings stay in the shared defines package. The block adds no new typedefs.
- Natural sub-module: sync_fifo_ctrl, holding pointers, occupancy, full/empty and almost-full compare, parameterised by depth and threshold. l2_response_queue instantiates it plus the packet storage array and the overflow flag.

Test Plan:
- Single packet, consumer ready:
  - Stimulus: push id=3, core=1, packet_type=L2RSP_LOAD_ACK in cycle 10, ready=1.
  - Required: l2rq_response_valid=1 with identical fields in cycle 11, occupancy returns to 0 in cycle 12.
- Ordering under backpressure:
  - Stimulus: ready=0, push ids 0..5 on consecutive cycles.
  - Required: occupancy=6, almost_full=1 once occupancy reaches 4. Then ready=1: ids pop out 0..5 in order, and almost_full drops once occupancy reaches 3.
- Full plus simultaneous push and pop:
  - Stimulus: fill to 8, then push id=9 with ready=1 in the same cycle.
  - Required: occupancy stays 8, overflow=0, id=9 is later delivered last.
- Overflow:
  - Stimulus: occupancy 8, ready=0, push id=A.
  - Required: overflow=1 from the next cycle, occupancy stays 8, id=A is never delivered, overflow stays 1 until reset.
- Wrap-around:
  - Stimulus: 20 packets streamed with ready toggling 1,0,1,0.
  - Required: all 20 delivered in order with data bit-exact; pointers cross index 7 to 0 twice.
- Reset mid-operation:
  - Stimulus: occupancy 5, overflow=1, assert reset=0 for one cycle while l2_response_valid=1.
  - Required: next cycle valid=0, occupancy=0, almost_full=0, overflow=0, and the in-flight push is discarded.

Source files
------------

// File: rtl/l2_response_queue_pkg.sv
// ---------------------------------------------------------------------------
// l2_response_queue_pkg
//   Shared L2 response definitions: the response packet layout and the
//   L2RSP_* field encodings used by the update stage, the response queue
//   and the core interconnect.
//
//   No ports (package).
// ---------------------------------------------------------------------------
package l2_response_queue_pkg;

    localparam int L2RSP_CORE_W = 2;
    localparam int L2RSP_ID_W   = 4;
    localparam int L2RSP_DATA_W = 64;
    localparam int L2RSP_ADDR_W = 40;

    typedef enum logic [1:0] {
        L2RSP_LOAD_ACK   = 2'd0,
        L2RSP_STORE_ACK  = 2'd1,
        L2RSP_FLUSH_ACK  = 2'd2,
        L2RSP_IINVAL_ACK = 2'd3
    } l2rsp_type_t;

    typedef enum logic {
        L2RSP_CACHE_DCACHE = 1'b0,
        L2RSP_CACHE_ICACHE = 1'b1
    } l2rsp_cache_t;

    typedef struct packed {
        logic                    status;
        logic [L2RSP_CORE_W-1:0] core;
        logic [L2RSP_ID_W-1:0]   id;
        l2rsp_type_t             packet_type;
        l2rsp_cache_t            cache_type;
        logic [L2RSP_DATA_W-1:0] data;
        logic [L2RSP_ADDR_W-1:0] address;
    } l2rsp_packet_t;

endpackage

// File: rtl/l2_response_queue_sync_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// sync_fifo_ctrl
//   Pointer/occupancy bookkeeping for a single-clock FIFO whose producer
//   cannot be stalled. Decides which pushes and pops take effect, tracks
//   head/tail pointers and the entry count, and flags pushes that must be
//   dropped because the FIFO is full with no pop in the same cycle.
//
//   Ports:
//     clk          in   clock, rising edge
//     reset        in   synchronous active-low reset
//     push_req     in   producer presents an entry this cycle
//     pop_req      in   consumer accepts the head entry this cycle
//     push_en      out  push takes effect (write storage at wr_ptr)
//     pop_en       out  pop takes effect
//     drop         out  push requested while full and not popping
//     wr_ptr       out  tail index
//     rd_ptr       out  head index
//     count        out  number of stored entries, 0..DEPTH
//     empty        out  count == 0
//     almost_full  out  count >= THRESHOLD
// ---------------------------------------------------------------------------
module sync_fifo_ctrl
    import l2_response_queue_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int THRESHOLD = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_req,
    input  logic                       pop_req,
    output logic                       push_en,
    output logic                       pop_en,
    output logic                       drop,
    output logic [$clog2(DEPTH)-1:0]   wr_ptr,
    output logic [$clog2(DEPTH)-1:0]   rd_ptr,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       almost_full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] THRESH_C = CW'(THRESHOLD);

    logic full;

    always_comb begin
        empty   = (count == '0);
        full    = (count == DEPTH_C);
        pop_en  = pop_req && !empty;
        // A full FIFO can still take a push when the head leaves in the
        // same cycle: the freed slot is reused immediately.
        push_en = push_req && (!full || pop_en);
        drop    = push_req && full && !pop_en;
    end

    // Compare on the registered count so almost_full has no path from
    // the same-cycle push/pop inputs.
    assign almost_full = (count >= THRESH_C);

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // DEPTH is a power of two, so natural overflow of the pointer
            // width gives the modulo wrap.
            if (push_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_en) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_en, pop_en})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/l2_response_queue.sv
// ---------------------------------------------------------------------------
// l2_response_queue
//   Buffers response packets from the L2 update stage (which cannot stall)
//   and presents them to the core interconnect with valid/ready flow
//   control. Upstream backpressure is an almost-full indication that the
//   L2 request arbiter uses to stop admitting requests, leaving enough
//   room for the PIPELINE_SLACK responses already in flight.
//
//   Ports:
//     clk                  in   clock, rising edge
//     reset                in   synchronous active-low reset
//     l2_response_valid    in   packet valid from the update stage
//     l2_response          in   packet from the update stage
//     l2rq_response_valid  out  head packet valid to the cores
//     l2rq_response        out  head packet
//     l2rq_response_ready  in   consumer accepts the head packet
//     l2rq_almost_full     out  stop issuing new L2 requests
//     l2rq_overflow        out  sticky: a packet was dropped
//     l2rq_occupancy       out  current entry count
// ---------------------------------------------------------------------------
module l2_response_queue
    import l2_response_queue_pkg::*;
#(
    parameter int FIFO_DEPTH            = 8,
    parameter int PIPELINE_SLACK        = 4,
    parameter int ALMOST_FULL_THRESHOLD = FIFO_DEPTH - PIPELINE_SLACK
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          l2_response_valid,
    input  l2rsp_packet_t                 l2_response,
    output logic                          l2rq_response_valid,
    output l2rsp_packet_t                 l2rq_response,
    input  logic                          l2rq_response_ready,
    output logic                          l2rq_almost_full,
    output logic                          l2rq_overflow,
    output logic [$clog2(FIFO_DEPTH):0]   l2rq_occupancy
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic          push_en;
    logic          pop_en;
    logic          drop;
    logic          empty;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // Packet storage; deliberately not reset, only the pointers are.
    l2rsp_packet_t mem [FIFO_DEPTH];

    sync_fifo_ctrl #(
        .DEPTH     (FIFO_DEPTH),
        .THRESHOLD (ALMOST_FULL_THRESHOLD)
    ) u_ctrl (
        .clk         (clk),
        .reset       (reset),
        .push_req    (l2_response_valid),
        .pop_req     (l2rq_response_ready),
        .push_en     (push_en),
        .pop_en      (pop_en),
        .drop        (drop),
        .wr_ptr      (wr_ptr),
        .rd_ptr      (rd_ptr),
        .count       (l2rq_occupancy),
        .empty       (empty),
        .almost_full (l2rq_almost_full)
    );

    // A push coinciding with reset is ignored; gating the write keeps the
    // storage untouched in that cycle as well.
    always_ff @(posedge clk) begin
        if (reset && push_en) begin
            mem[wr_ptr] <= l2_response;
        end
    end

    // Output is read from registered pointers only, so a packet pushed in
    // one cycle appears at the earliest in the next.
    assign l2rq_response_valid = !empty;
    assign l2rq_response       = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!reset) begin
            l2rq_overflow <= 1'b0;
        end else begin
            if (drop) begin
                l2rq_overflow <= 1'b1;
            end
            assert (!drop)
                else $info("l2_response_queue: response dropped, queue full");
        end
    end

endmodule

// File: tb/tb_l2_response_queue.sv
// ---------------------------------------------------------------------------
// tb_l2_response_queue
//   Directed scenarios plus randomized traffic for l2_response_queue,
//   compared every cycle against a queue-based reference model.
// ---------------------------------------------------------------------------
module tb_l2_response_queue;
    import l2_response_queue_pkg::*;

    localparam int DEPTH  = 8;
    localparam int THRESH = 4;

    logic          clk;
    logic          reset;
    logic          l2_response_valid;
    l2rsp_packet_t l2_response;
    logic          l2rq_response_valid;
    l2rsp_packet_t l2rq_response;
    logic          l2rq_response_ready;
    logic          l2rq_almost_full;
    logic          l2rq_overflow;
    logic [3:0]    l2rq_occupancy;

    int checks = 0;
    int errors = 0;
    int deliv  = 0;

    // Reference model: contents of the queue in delivery order.
    l2rsp_packet_t mq[$];
    bit            m_ovf   = 1'b0;
    bit            m_known = 1'b0;

    l2_response_queue #(
        .FIFO_DEPTH     (DEPTH),
        .PIPELINE_SLACK (4)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .l2_response_valid   (l2_response_valid),
        .l2_response         (l2_response),
        .l2rq_response_valid (l2rq_response_valid),
        .l2rq_response       (l2rq_response),
        .l2rq_response_ready (l2rq_response_ready),
        .l2rq_almost_full    (l2rq_almost_full),
        .l2rq_overflow       (l2rq_overflow),
        .l2rq_occupancy      (l2rq_occupancy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic l2rsp_packet_t mk_pkt(input logic [3:0] id, input logic [1:0] core,
                                             input l2rsp_type_t t);
        l2rsp_packet_t p;
        p.status      = 1'($urandom);
        p.core        = core;
        p.id          = id;
        p.packet_type = t;
        p.cache_type  = l2rsp_cache_t'($urandom_range(0, 1));
        p.data        = {$urandom, $urandom};
        p.address     = {8'($urandom), $urandom};
        return p;
    endfunction

    function automatic l2rsp_packet_t rnd_pkt();
        return mk_pkt(4'($urandom), 2'($urandom), l2rsp_type_t'($urandom_range(0, 3)));
    endfunction

    task automatic check_outputs();
        if (m_known) begin
            chk("valid",       128'(l2rq_response_valid), 128'(mq.size() != 0));
            chk("occupancy",   128'(l2rq_occupancy),      128'(mq.size()));
            chk("almost_full", 128'(l2rq_almost_full),    128'(mq.size() >= THRESH));
            chk("overflow",    128'(l2rq_overflow),       128'(m_ovf));
            if (mq.size() != 0) begin
                chk("head_packet", 128'(l2rq_response), 128'(mq[0]));
            end
        end
    endtask

    // Applies the queue rules to the inputs presented for the coming edge.
    task automatic model_step();
        int n;
        bit pop;
        n = mq.size();
        if (!reset) begin
            mq.delete();
            m_ovf   = 1'b0;
            m_known = 1'b1;
        end else if (m_known) begin
            pop = (n != 0) && l2rq_response_ready;
            if (pop) mq.delete(0);
            if (l2_response_valid) begin
                if (n < DEPTH || pop) mq.push_back(l2_response);
                else                  m_ovf = 1'b1;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check_outputs();
        if (reset && l2rq_response_valid && l2rq_response_ready) deliv++;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rst_n, input logic v, input l2rsp_packet_t p, input logic rdy);
        reset               = rst_n;
        l2_response_valid   = v;
        l2_response         = p;
        l2rq_response_ready = rdy;
        tick();
    endtask

    initial begin
        l2rsp_packet_t idle;
        idle = '0;
        reset = 1'b0;
        l2_response_valid = 1'b0;
        l2_response = idle;
        l2rq_response_ready = 1'b0;

        // Reset, then idle up to cycle 10.
        repeat (2) drive(1'b0, 1'b0, idle, 1'b0);
        repeat (7) drive(1'b1, 1'b0, idle, 1'b0);

        // Single packet with the consumer ready.
        drive(1'b1, 1'b1, mk_pkt(4'd3, 2'd1, L2RSP_LOAD_ACK), 1'b1);
        repeat (3) drive(1'b1, 1'b0, idle, 1'b1);

        // Ordering under backpressure, then drain.
        for (int i = 0; i < 6; i++) drive(1'b1, 1'b1, rnd_pkt_id(4'(i)), 1'b0);
        repeat (8) drive(1'b1, 1'b0, idle, 1'b1);

        // Full with simultaneous push and pop.
        for (int i = 0; i < 8; i++) drive(1'b1, 1'b1, rnd_pkt_id(4'(i)), 1'b0);
        drive(1'b1, 1'b1, rnd_pkt_id(4'd9), 1'b1);
        repeat (10) drive(1'b1, 1'b0, idle, 1'b1);

        // Overflow: full, not ready, extra push is dropped.
        for (int i = 0; i < 8; i++) drive(1'b1, 1'b1, rnd_pkt_id(4'(i)), 1'b0);
        drive(1'b1, 1'b1, rnd_pkt_id(4'hA), 1'b0);
        repeat (3) drive(1'b1, 1'b0, idle, 1'b0);
        repeat (10) drive(1'b1, 1'b0, idle, 1'b1);

        // Reset mid-operation with overflow still set and a push in flight.
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, rnd_pkt_id(4'(i)), 1'b0);
        drive(1'b0, 1'b1, rnd_pkt_id(4'd7), 1'b0);
        repeat (2) drive(1'b1, 1'b0, idle, 1'b0);

        // Wrap-around: 20 packets, one every other cycle, ready toggling.
        deliv = 0;
        for (int i = 0; i < 40; i++) begin
            drive(1'b1, (i % 2 == 0), rnd_pkt_id(4'(i / 2)), (i % 2 == 1));
        end
        repeat (10) drive(1'b1, 1'b0, idle, 1'b1);
        chk("wrap_delivered", 128'(deliv), 128'(20));

        // Randomized traffic: slow consumer first, then a fast one.
        for (int c = 0; c < 3000; c++) begin
            drive(($urandom_range(0, 199) != 0),
                  ($urandom_range(0, 99) < 60),
                  rnd_pkt(),
                  ($urandom_range(0, 99) < ((c < 1500) ? 35 : 65)));
        end
        repeat (12) drive(1'b1, 1'b0, idle, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    function automatic l2rsp_packet_t rnd_pkt_id(input logic [3:0] id);
        return mk_pkt(id, 2'($urandom), l2rsp_type_t'($urandom_range(0, 3)));
    endfunction

endmodule
